// File: rtl/clk_meter_pkg.sv
// rtl/clk_meter_pkg.sv - shared types and constants for the clock period meter
package clk_meter_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_RISE,
        MEAS
    } meter_state_t;

    localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/sync_edge_det.sv
// rtl/sync_edge_det.sv - synchronizer plus delay flop producing rise/fall strobes
module sync_edge_det
    import clk_meter_pkg::*;
#(
    parameter int STAGES = SYNC_STAGES
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic              dly;

    // Shift the async input through the synchronizer, then keep one cycle of history
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            dly    <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], din};
            dly    <= sync_q[STAGES-1];
        end
    end

    assign rise = sync_q[STAGES-1] & ~dly;
    assign fall = ~sync_q[STAGES-1] & dly;

endmodule

// File: rtl/clk_period_meter.sv
// rtl/clk_period_meter.sv - measures period/high time of a slow async clock and reports lock
module clk_period_meter
    import clk_meter_pkg::*;
#(
    parameter int CNT_W    = 16,
    parameter int LOCK_CNT = 4,
    parameter int TOL      = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             meas_clk,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             valid,
    output logic             locked,
    output logic             timeout
);

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [3:0]       LOCK_MAX = 4'(LOCK_CNT);
    localparam logic [CNT_W:0]   TOL_W    = (CNT_W+1)'(TOL);

    meter_state_t     state, state_next;
    logic             rise, fall;
    logic [CNT_W-1:0] cnt, hi_next, prev_period;
    logic             hi_seen, have_prev;
    logic [3:0]       match_cnt, match_inc;
    logic             publish, expire;
    logic [CNT_W:0]   diff;
    logic             close_enough;

    sync_edge_det #(.STAGES(SYNC_STAGES)) u_edge (
        .clk  (clk),
        .rst  (rst),
        .din  (meas_clk),
        .rise (rise),
        .fall (fall)
    );

    // Magnitude of the change from the previous period; the first period has no predecessor
    always_comb begin
        diff = '0;
        if (cnt >= prev_period) diff = {1'b0, cnt} - {1'b0, prev_period};
        else                    diff = {1'b0, prev_period} - {1'b0, cnt};
        close_enough = have_prev && (diff <= TOL_W);
        match_inc    = (match_cnt == LOCK_MAX) ? LOCK_MAX : match_cnt + 4'd1;
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next state plus the publish/expire strobes that drive the datapath
    always_comb begin
        state_next = state;
        publish    = 1'b0;
        expire     = 1'b0;
        if (!en) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:      state_next = WAIT_RISE;
                WAIT_RISE: if (rise) state_next = MEAS;
                MEAS: begin
                    if (rise) begin
                        publish = 1'b1;
                    end else if (cnt == CNT_MAX) begin
                        expire     = 1'b1;
                        state_next = WAIT_RISE;
                    end
                end
                default:   state_next = IDLE;
            endcase
        end
    end

    // Counter, result registers and lock tracking
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt         <= '0;
            hi_next     <= '0;
            hi_seen     <= 1'b0;
            prev_period <= '0;
            have_prev   <= 1'b0;
            match_cnt   <= '0;
            period      <= '0;
            high_time   <= '0;
            valid       <= 1'b0;
            locked      <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            valid   <= publish;
            timeout <= expire;
            if (!en || state == IDLE) begin
                cnt       <= '0;
                hi_seen   <= 1'b0;
                have_prev <= 1'b0;
                match_cnt <= '0;
                locked    <= 1'b0;
            end else if (state == WAIT_RISE) begin
                if (rise) begin
                    cnt     <= CNT_W'(1);
                    hi_seen <= 1'b0;
                    hi_next <= '0;
                end
            end else if (rise) begin
                period      <= cnt;
                high_time   <= hi_seen ? hi_next : '0;
                cnt         <= CNT_W'(1);
                hi_seen     <= 1'b0;
                prev_period <= cnt;
                have_prev   <= 1'b1;
                if (close_enough) begin
                    match_cnt <= match_inc;
                    locked    <= (match_inc == LOCK_MAX);
                end else begin
                    match_cnt <= '0;
                    locked    <= 1'b0;
                end
            end else if (cnt == CNT_MAX) begin
                cnt       <= '0;
                have_prev <= 1'b0;
                match_cnt <= '0;
                locked    <= 1'b0;
            end else begin
                cnt <= cnt + CNT_W'(1);
                if (fall) begin
                    hi_next <= cnt;
                    hi_seen <= 1'b1;
                end
            end
        end
    end

endmodule
